dom_fresh_mask_source: RTL



---
 rtl/dom_rng_pkg.sv | 32 +++
 rtl/dom_lfsr32.sv | 30 +++
 rtl/dom_fresh_mask_source.sv | 115 +++++++++++
 3 files changed

// File: rtl/dom_rng_pkg.sv
// Shared constants, state encoding and width helpers for the DOM fresh-mask source.
package dom_rng_pkg;

  localparam int          LFSR_W    = 32;
  // Feedback taps of x^32+x^22+x^2+x+1 on the state bits s[31], s[21], s[1], s[0].
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // Substituted for an all-zero seed so no LFSR can start in the lock-up state.
  localparam logic [31:0] ZERO_SUB  = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_LOADING  = 2'd1,
    ST_WARMUP   = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  // Fresh-mask width of one DOM multiplier.
  function automatic int zw(input int shares);
    return shares * (shares - 1);
  endfunction

  // Blinding-bit width of one DOM multiplier.
  function automatic int bw(input int shares);
    return 2 * shares;
  endfunction

  // Number of LFSRs, one per output mask bit.
  function automatic int k(input int shares);
    return 3 * zw(shares) + 3 * bw(shares);
  endfunction

endpackage

// File: rtl/dom_lfsr32.sv
// One seeded 32-bit Fibonacci LFSR; emits its MSB as one fresh mask bit.
module dom_lfsr32
  import dom_rng_pkg::*;
(
  input  logic              ClkxCI,
  input  logic              RstxRI,
  input  logic              LoadxSI,
  input  logic              StepxSI,
  input  logic [LFSR_W-1:0] DinxDI,
  output logic              BitxDO
);

  logic [LFSR_W-1:0] SxDP;

  // Load a (zero-substituted) seed, or shift in the XOR of the tap bits.
  // NOTE: the LFSR state is reset to a non-zero value on purpose; an all-zero register would never leave zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      SxDP <= ZERO_SUB;
    end else if (LoadxSI) begin
      SxDP <= (DinxDI == '0) ? ZERO_SUB : DinxDI;
    end else if (StepxSI) begin
      SxDP <= {SxDP[LFSR_W-2:0], ^(SxDP & LFSR_TAPS)};
    end
  end

  assign BitxDO = SxDP[LFSR_W-1];

endmodule

// File: rtl/dom_fresh_mask_source.sv
// Fresh-randomness source for the masked DOM AES S-box: seed loading, warm-up,
// lock-step advance and packing of the per-bit LFSR outputs into mask buses.
module dom_fresh_mask_source
  import dom_rng_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int WARMUP = 32
) (
  input  logic                    ClkxCI,
  input  logic                    RstxRI,
  input  logic                    SeedStartxSI,
  input  logic [LFSR_W-1:0]       SeedxDI,
  input  logic                    SeedValidxSI,
  output logic                    SeedReadyxSO,
  input  logic                    EnxSI,
  output logic                    ValidxSO,
  output logic [zw(SHARES)-1:0]   _Zmul1xDO,
  output logic [zw(SHARES)-1:0]   _Zmul2xDO,
  output logic [zw(SHARES)-1:0]   _Zmul3xDO,
  output logic [bw(SHARES)-1:0]   _Bmul1xDO,
  output logic [bw(SHARES)-1:0]   _Bmul2xDO,
  output logic [bw(SHARES)-1:0]   _Bmul3xDO
);

  localparam int ZW     = zw(SHARES);
  localparam int BW     = bw(SHARES);
  localparam int K      = k(SHARES);
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(K - 1);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP - 1);

  state_t             StatexDP, StatexDN;
  logic [IDX_W-1:0]   IdxxDP;
  logic [WCNT_W-1:0]  WarmCntxDP;
  logic               AcceptxS;
  logic               LastWordxS;
  logic               StepAllxS;
  logic [K-1:0]       RxD;

  assign LastWordxS = (IdxxDP == IDX_LAST);

  // Next-state decode; a seed restart overrides every state and ignores a same-cycle word.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    StatexDN  = StatexDP;
    AcceptxS  = 1'b0;
    StepAllxS = 1'b0;
    if (SeedStartxSI) begin
      StatexDN = ST_LOADING;
    end else begin
      case (StatexDP)
        ST_LOADING: begin
          if (SeedValidxSI) begin
            AcceptxS = 1'b1;
            if (LastWordxS) StatexDN = ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          StepAllxS = 1'b1;
          if (WarmCntxDP == WARM_LAST) StatexDN = ST_RUN;
        end
        ST_RUN: begin
          StepAllxS = EnxSI;
        end
        default: ;
      endcase
    end
  end

  // State, seed index and warm-up counter registers.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      StatexDP   <= ST_UNSEEDED;
      IdxxDP     <= '0;
      WarmCntxDP <= '0;
    end else begin
      StatexDP <= StatexDN;
      if (SeedStartxSI) begin
        IdxxDP <= '0;
      end else if (AcceptxS) begin
        IdxxDP <= LastWordxS ? '0 : IdxxDP + IDX_W'(1);
      end
      if (AcceptxS && LastWordxS) begin
        WarmCntxDP <= '0;
      end else if (StatexDP == ST_WARMUP) begin
        WarmCntxDP <= WarmCntxDP + WCNT_W'(1);
      end
    end
  end

  // One LFSR per mask bit; only the LFSR addressed by the seed index loads.
  for (genvar g = 0; g < K; g++) begin : g_lfsr
    dom_lfsr32 u_lfsr (
      .ClkxCI  (ClkxCI),
      .RstxRI  (RstxRI),
      .LoadxSI (AcceptxS && (IdxxDP == IDX_W'(g))),
      .StepxSI (StepAllxS),
      .DinxDI  (SeedxDI),
      .BitxDO  (RxD[g])
    );
  end

  assign SeedReadyxSO = (StatexDP == ST_LOADING);
  assign ValidxSO     = (StatexDP == ST_RUN);

  assign _Zmul1xDO = RxD[0*ZW +: ZW];
  assign _Zmul2xDO = RxD[1*ZW +: ZW];
  assign _Zmul3xDO = RxD[2*ZW +: ZW];
  assign _Bmul1xDO = RxD[3*ZW + 0*BW +: BW];
  assign _Bmul2xDO = RxD[3*ZW + 1*BW +: BW];
  assign _Bmul3xDO = RxD[3*ZW + 2*BW +: BW];

endmodule
